// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: widths, op codes, FSM states.
package muldiv_unit_pkg;

  localparam int MD_DATA_W = 32;
  localparam int MD_CNT_W  = 6;

  // Op codes line up with the EX-stage EXE_MULT/MULTU/DIV/DIVU encodings.
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_DIVZ = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One combinational radix-2 restoring division iteration.
module muldiv_unit_div_step
  import muldiv_unit_pkg::*;
#(
  parameter int W = MD_DATA_W
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] w_shift;
  logic [W:0] w_diff;

  // One extra bit: the shifted remainder can reach 2*divisor-1.
  assign w_shift = {rem_i, bit_i};
  assign w_diff  = w_shift - {1'b0, divisor_i};
  assign q_o     = (w_shift >= {1'b0, divisor_i});
  assign rem_o   = q_o ? w_diff[W-1:0] : w_shift[W-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit for the EX stage; returns {HI, LO} with a one-cycle ready.
// Handshake: start_i is taken only in IDLE (annul_i low); ready_o pulses once with result_o valid, no backpressure.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_W = MD_DATA_W,
  parameter int CNT_W  = MD_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [1:0]          op_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                annul_i,
  output logic                busy_o,
  output logic                stall_req_o,
  output logic                ready_o,
  output logic [2*DATA_W-1:0] result_o,
  output state_t              dbg_state_o
);

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_op;
  logic [DATA_W-1:0]   r_quo;
  logic [DATA_W-1:0]   r_dvs;
  logic [DATA_W-1:0]   r_rem;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [2*DATA_W-1:0] r_result;

  logic                w_accept;
  logic                w_signed_div;
  logic [DATA_W-1:0]   w_abs1;
  logic [DATA_W-1:0]   w_abs2;
  logic                w_last;
  logic [DATA_W-1:0]   w_rem_nxt;
  logic                w_qbit;
  logic [DATA_W-1:0]   w_quo_final;
  logic [DATA_W-1:0]   w_quo_fix;
  logic [DATA_W-1:0]   w_rem_fix;
  logic                w_mul_signed;
  logic [2*DATA_W-1:0] w_ext_a;
  logic [2*DATA_W-1:0] w_ext_b;
  logic [2*DATA_W-1:0] w_prod;

  assign w_accept     = !rst && (r_state == ST_IDLE) && start_i && !annul_i;
  assign w_signed_div = (op_i == OP_DIV);
  // Negating 0x80000000 yields itself, which is the right unsigned magnitude.
  assign w_abs1 = (w_signed_div && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign w_abs2 = (w_signed_div && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  assign w_last = (r_cnt == CNT_W'(DATA_W - 1));

  muldiv_unit_div_step #(.W(DATA_W)) u_div_step (
    .rem_i     (r_rem),
    .bit_i     (r_quo[DATA_W-1]),
    .divisor_i (r_dvs),
    .rem_o     (w_rem_nxt),
    .q_o       (w_qbit)
  );

  assign w_quo_final = {r_quo[DATA_W-2:0], w_qbit};
  assign w_quo_fix   = r_neg_q ? -w_quo_final : w_quo_final;
  assign w_rem_fix   = r_neg_r ? -w_rem_nxt : w_rem_nxt;

  // Extending to full width first gives the correct low 2*DATA_W product bits either way.
  assign w_mul_signed = (r_op == OP_MULT);
  assign w_ext_a = w_mul_signed ? {{DATA_W{r_quo[DATA_W-1]}}, r_quo} : {{DATA_W{1'b0}}, r_quo};
  assign w_ext_b = w_mul_signed ? {{DATA_W{r_dvs[DATA_W-1]}}, r_dvs} : {{DATA_W{1'b0}}, r_dvs};
  assign w_prod  = w_ext_a * w_ext_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!op_i[1])                 w_next = ST_MUL;
          else if (opdata2_i == '0)     w_next = ST_DIVZ;
          else                          w_next = ST_DIV;
        end
      end
      ST_MUL, ST_DIVZ: w_next = annul_i ? ST_IDLE : ST_DONE;
      ST_DIV: begin
        if (annul_i)     w_next = ST_IDLE;
        else if (w_last) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= OP_MULT;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= op_i;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= op_i[1] ? w_abs1 : opdata1_i;
            r_dvs   <= op_i[1] ? w_abs2 : opdata2_i;
            r_neg_q <= w_signed_div && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            r_neg_r <= w_signed_div && opdata1_i[DATA_W-1];
          end
        end
        ST_MUL: begin
          if (!annul_i) r_result <= w_prod;
        end
        ST_DIVZ: begin
          if (!annul_i) r_result <= '0;
        end
        ST_DIV: begin
          if (!annul_i) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_final;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_result <= {w_rem_fix, w_quo_fix};
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = (r_state != ST_IDLE);
  assign ready_o     = (r_state == ST_DONE);
  assign stall_req_o = w_accept || (r_state == ST_MUL) || (r_state == ST_DIV) ||
                       (r_state == ST_DIVZ);
  assign result_o    = r_result;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model with per-cycle compare plus literal checks.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic        busy_o;
  logic        stall_req_o;
  logic        ready_o;
  logic [63:0] result_o;
  state_t      dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  muldiv_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .op_i        (op_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .annul_i     (annul_i),
    .busy_o      (busy_o),
    .stall_req_o (stall_req_o),
    .ready_o     (ready_o),
    .result_o    (result_o),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the MIPS definitions.
  function automatic logic [63:0] model_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return ua * ub;
      OP_DIV: begin
        if (b == 32'd0) return 64'd0;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return 64'd0;
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Model: an accepted op completes after a fixed number of edges unless annulled.
  bit          m_active;
  bit          m_ready;
  int          m_left;
  logic [63:0] m_res;
  logic [63:0] m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_ready  <= 1'b0;
      m_left   <= 0;
      m_res    <= 64'd0;
      m_pend   <= 64'd0;
    end else if (m_ready) begin
      m_ready <= 1'b0;
    end else if (m_active) begin
      if (annul_i) m_active <= 1'b0;
      else if (m_left == 1) begin
        m_active <= 1'b0;
        m_ready  <= 1'b1;
        m_res    <= m_pend;
      end else m_left <= m_left - 1;
    end else if (start_i && !annul_i) begin
      m_active <= 1'b1;
      m_left   <= (op_i[1] && opdata2_i != 32'd0) ? 32 : 1;
      m_pend   <= model_result(op_i, opdata1_i, opdata2_i);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy",   64'(busy_o),  64'(m_active || m_ready));
      check("ready",  64'(ready_o), 64'(m_ready));
      check("stall",  64'(stall_req_o),
            64'(m_active || (!m_ready && start_i && !annul_i)));
      check("result", result_o, m_res);
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    start_i   = 1'b1;
    op_i      = op;
    opdata1_i = a;
    opdata2_i = b;
    @(posedge clk);
    #1;
    start_i   = 1'b0;
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    op_i      = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_ready(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready_o && n < 100);
    if (!ready_o) check({name, "_timeout"}, 64'(ready_o), 64'd1);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
    int n;
    issue(op, a, b);
    wait_ready(name, n);
    check({name, "_latency"}, 64'(n), 64'(exp_lat));
    check({name, "_result"}, result_o, exp_res);
    check({name, "_stall_in_done"}, 64'(stall_req_o), 64'd0);
    @(negedge clk);
    check({name, "_idle_after"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; op_i = 2'b00; opdata1_i = '0; opdata2_i = '0; annul_i = 1'b0;
    #12;
    check("reset_result", result_o, 64'd0);
    check("reset_busy",   64'(busy_o), 64'd0);
    check("reset_ready",  64'(ready_o), 64'd0);
    check("reset_stall",  64'(stall_req_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("divu_100_7",  OP_DIVU,  32'd100,       32'd7,          33, {32'd2, 32'd14});
    run_op("div_m7_2",    OP_DIV,   32'hFFFFFFF9,  32'd2,          33, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op("mult_m3_5",   OP_MULT,  32'hFFFFFFFD,  32'd5,          2,  64'hFFFFFFFF_FFFFFFF1);
    run_op("multu_max_2", OP_MULTU, 32'hFFFFFFFF,  32'd2,          2,  64'h00000001_FFFFFFFE);
    run_op("div_by_zero", OP_DIV,   32'h1234,      32'd0,          2,  64'd0);
    run_op("div_minneg",  OP_DIV,   32'h80000000,  32'hFFFFFFFF,   33, {32'd0, 32'h80000000});
    run_op("div_7_m2",    OP_DIV,   32'd7,         32'hFFFFFFFE,   33, {32'd1, 32'hFFFFFFFD});
    run_op("div_m8_m3",   OP_DIV,   32'hFFFFFFF8,  32'hFFFFFFFD,   33, {32'hFFFFFFFE, 32'd2});
    run_op("divu_max_1",  OP_DIVU,  32'hFFFFFFFF,  32'd1,          33, {32'd0, 32'hFFFFFFFF});
    run_op("divu_zero",   OP_DIVU,  32'd55,        32'd0,          2,  64'd0);
    run_op("mult_neg",    OP_MULT,  32'h80000000,  32'h80000000,   2,  64'h40000000_00000000);

    // Annul in the middle of a division: back to IDLE, result untouched.
    run_op("divu_seed",   OP_DIVU,  32'd100,       32'd7,          33, {32'd2, 32'd14});
    issue(OP_DIV, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    #1 annul_i = 1'b1;
    @(posedge clk);
    #1 annul_i = 1'b0;
    check("annul_busy", 64'(busy_o), 64'd0);
    check("annul_result_kept", result_o, {32'd2, 32'd14});
    run_op("divu_9_3",    OP_DIVU,  32'd9,         32'd3,          33, {32'd0, 32'd3});

    // Start together with annul in IDLE is dropped.
    @(posedge clk);
    #1; start_i = 1'b1; annul_i = 1'b1; op_i = OP_MULT; opdata1_i = 32'd3; opdata2_i = 32'd3;
    @(posedge clk);
    #1; start_i = 1'b0; annul_i = 1'b0;
    check("annul_start_idle", 64'(busy_o), 64'd0);

    // A start pulse while busy must not disturb the running division.
    begin
      int n;
      issue(OP_DIVU, 32'd100, 32'd7);
      repeat (5) @(posedge clk);
      #1; start_i = 1'b1; op_i = OP_MULT; opdata1_i = 32'd1; opdata2_i = 32'd1;
      @(posedge clk);
      #1; start_i = 1'b0;
      wait_ready("busy_start", n);
      check("busy_start_result", result_o, {32'd2, 32'd14});
    end

    // Annul arriving in DONE does not cancel the ready pulse.
    issue(OP_MULTU, 32'd3, 32'd4);
    @(posedge clk);
    #1 annul_i = 1'b1;
    @(negedge clk);
    check("annul_done_ready", 64'(ready_o), 64'd1);
    check("annul_done_result", result_o, 64'd12);
    @(posedge clk);
    #1 annul_i = 1'b0;

    // Asynchronous reset mid-division clears everything at once.
    issue(OP_DIV, 32'd1000, 32'd7);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_busy",   64'(busy_o), 64'd0);
    check("midrst_ready",  64'(ready_o), 64'd0);
    check("midrst_stall",  64'(stall_req_o), 64'd0);
    check("midrst_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("multu_6_7",   OP_MULTU, 32'd6,         32'd7,          2,  {32'd0, 32'd42});

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
